// File: rtl/encoder8to3_pend.sv
// -----------------------------------------------------------------------------
// encoder8to3_pend
//
// Pending-request priority encoder with a present/acknowledge handshake.
// Requests on A (qualified by EN) are merged into a sticky pending register.
// When idle, the highest-priority pending bit is encoded onto Y and presented
// with V=1. The code holds until the consumer asserts ACK, which clears that
// pending bit and returns the block to idle. ACK while nothing is presented
// raises a sticky error flag.
//
// Parameters
//   HIGH_FIRST : 1 = bit 7 has highest priority, 0 = bit 0 has highest priority
//
// Ports
//   clk   in   1  clock, rising-edge active
//   rst_n in   1  synchronous active-low reset
//   A     in   8  request lines, bit k requests code k
//   EN    in   1  request capture enable
//   ACK   in   1  consumer accepts the presented code
//   Y     out  3  granted code (registered)
//   V     out  1  Y valid (registered, equals the PRESENT state bit)
//   PEND  out  8  pending-request register
//   ERR   out  1  sticky protocol-error flag (ACK while V=0)
// -----------------------------------------------------------------------------
module encoder8to3_pend #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic       EN,
    input  logic       ACK,
    output logic [2:0] Y,
    output logic       V,
    output logic [7:0] PEND,
    output logic       ERR
);

    // Single-bit encoding so V is the state flop itself.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [2:0] y_next;
    logic [7:0] pend_next;
    logic [7:0] clr;
    logic       err_next;

    // Index of the highest-priority set bit. Scanning from the lowest-priority
    // end and overwriting on each hit leaves the highest-priority index.
    function automatic logic [2:0] prio(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (HIGH_FIRST) begin
                if (req[i]) idx = 3'(i);
            end else begin
                if (req[7 - i]) idx = 3'(7 - i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next = state;
        y_next     = Y;
        err_next   = ERR;
        clr        = 8'h00;

        unique case (state)
            IDLE: begin
                // Nothing is presented, so an ACK here is a protocol error and
                // must not touch state or PEND.
                if (ACK) err_next = 1'b1;
                // Selection looks at the registered PEND, never at A directly.
                if (PEND != 8'h00) begin
                    y_next     = prio(PEND);
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                // Y is frozen here: new requests only accumulate in PEND.
                if (ACK) begin
                    clr        = 8'h01 << Y;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Set is applied after clear, so a same-cycle set of the acknowledged
        // bit keeps it pending.
        pend_next = (PEND & ~clr) | (A & {8{EN}});
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
            Y     <= 3'd0;
            PEND  <= 8'h00;
            ERR   <= 1'b0;
        end else begin
            state <= state_next;
            Y     <= y_next;
            PEND  <= pend_next;
            ERR   <= err_next;
        end
    end

    assign V = (state == PRESENT);

endmodule

// File: tb/tb_encoder8to3_pend.sv
// -----------------------------------------------------------------------------
// tb_encoder8to3_pend
//
// Directed bench for encoder8to3_pend. Two instances share the stimulus: one
// with HIGH_FIRST=1 (primary) and one with HIGH_FIRST=0 (priority order check).
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so each check reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_encoder8to3_pend;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic       en;
    logic       ack;

    logic [2:0] y_h, y_l;
    logic       v_h, v_l;
    logic [7:0] pend_h, pend_l;
    logic       err_h, err_l;

    int n_cmp;
    int n_err;

    encoder8to3_pend #(.HIGH_FIRST(1'b1)) u_hi (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a),
        .EN   (en),
        .ACK  (ack),
        .Y    (y_h),
        .V    (v_h),
        .PEND (pend_h),
        .ERR  (err_h)
    );

    encoder8to3_pend #(.HIGH_FIRST(1'b0)) u_lo (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a),
        .EN   (en),
        .ACK  (ack),
        .Y    (y_l),
        .V    (v_l),
        .PEND (pend_l),
        .ERR  (err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a     = 8'h00;
        en    = 1'b0;
        ack   = 1'b0;

        // Reset, with live inputs during the last reset edge to show they are dropped.
        tick();
        a = 8'hFF; en = 1'b1; ack = 1'b1;
        tick();
        check("rst_y",    {5'd0, y_h}, 8'h00);
        check("rst_v",    {7'd0, v_h}, 8'h00);
        check("rst_pend", pend_h,      8'h00);
        check("rst_err",  {7'd0, err_h}, 8'h00);
        rst_n = 1'b1; a = 8'h00; en = 1'b0; ack = 1'b0;

        // Single request: capture, present 2 cycles after A, acknowledge.
        a = 8'h20; en = 1'b1;
        tick();
        check("single_pend1", pend_h,      8'h20);
        check("single_v1",    {7'd0, v_h}, 8'h00);
        a = 8'h00; en = 1'b0;
        tick();
        check("single_v2",    {7'd0, v_h}, 8'h01);
        check("single_y2",    {5'd0, y_h}, 8'h05);
        ack = 1'b1;
        tick();
        check("single_v3",    {7'd0, v_h},   8'h00);
        check("single_pend3", pend_h,        8'h00);
        check("single_err3",  {7'd0, err_h}, 8'h00);
        ack = 1'b0;
        tick();
        check("single_idle",  {7'd0, v_h}, 8'h00);

        // Priority with ACK held high: one grant every 2 cycles.
        a = 8'h81; en = 1'b1; ack = 1'b1;
        tick();
        check("prio_pend",  pend_h, 8'h81);
        a = 8'h00; en = 1'b0;
        tick();
        check("prio_hi_y1", {5'd0, y_h}, 8'h07);
        check("prio_lo_y1", {5'd0, y_l}, 8'h00);
        check("prio_v1",    {6'd0, v_h, v_l}, 8'h03);
        tick();
        check("prio_hi_pend", pend_h, 8'h01);
        check("prio_lo_pend", pend_l, 8'h80);
        check("prio_gap_v",   {6'd0, v_h, v_l}, 8'h00);
        tick();
        check("prio_hi_y2", {5'd0, y_h}, 8'h00);
        check("prio_lo_y2", {5'd0, y_l}, 8'h07);
        check("prio_v2",    {6'd0, v_h, v_l}, 8'h03);
        tick();
        check("prio_hi_end", pend_h, 8'h00);
        check("prio_lo_end", pend_l, 8'h00);
        check("prio_err",    {6'd0, err_h, err_l}, 8'h03);
        ack = 1'b0;

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("err_cleared", {7'd0, err_h}, 8'h00);

        // No preemption, then set-wins re-pend on the acknowledged bit.
        a = 8'h04; en = 1'b1;
        tick();
        a = 8'h00; en = 1'b0;
        tick();
        check("np_y2", {5'd0, y_h}, 8'h02);
        a = 8'h80; en = 1'b1;
        tick();
        check("np_hold_y", {5'd0, y_h}, 8'h02);
        check("np_hold_v", {7'd0, v_h}, 8'h01);
        check("np_pend",   pend_h,      8'h84);
        a = 8'h84; ack = 1'b1;
        tick();
        check("repend_pend", pend_h,        8'h84);
        check("repend_v",    {7'd0, v_h},   8'h00);
        check("repend_err",  {7'd0, err_h}, 8'h00);
        a = 8'h00; en = 1'b0; ack = 1'b0;
        tick();
        check("repend_y7", {5'd0, y_h}, 8'h07);
        ack = 1'b1;
        tick();
        check("repend_pend2", pend_h, 8'h04);
        ack = 1'b0;
        tick();
        check("repend_y2", {5'd0, y_h}, 8'h02);
        check("repend_v2", {7'd0, v_h}, 8'h01);
        ack = 1'b1;
        tick();
        check("repend_done", pend_h, 8'h00);
        ack = 1'b0;

        // EN gating and the sticky error flag.
        a = 8'hFF; en = 1'b0;
        tick();
        tick();
        check("gate_pend", pend_h,      8'h00);
        check("gate_v",    {7'd0, v_h}, 8'h00);
        a = 8'h00; ack = 1'b1;
        tick();
        check("err_set",  {7'd0, err_h}, 8'h01);
        check("err_pend", pend_h,        8'h00);
        ack = 1'b0;
        tick();
        tick();
        check("err_held", {7'd0, err_h}, 8'h01);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Reset while presenting aborts the grant and drops pending requests.
        a = 8'h0C; en = 1'b1;
        tick();
        check("mid_pend", pend_h, 8'h0C);
        a = 8'h00; en = 1'b0;
        tick();
        check("mid_y3", {5'd0, y_h}, 8'h03);
        check("mid_v",  {7'd0, v_h}, 8'h01);
        rst_n = 1'b0;
        tick();
        check("mid_rst_y",    {5'd0, y_h},   8'h00);
        check("mid_rst_v",    {7'd0, v_h},   8'h00);
        check("mid_rst_pend", pend_h,        8'h00);
        check("mid_rst_err",  {7'd0, err_h}, 8'h00);
        rst_n = 1'b1;
        tick();
        tick();
        check("mid_no_grant", {7'd0, v_h}, 8'h00);
        check("mid_no_pend",  pend_h,      8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
